des_cbc_ctrl: RTL and testbench

- Block-mode sequencer that sits directly upstream and downstream of the iterative DES core.
- Accepts 64-bit plaintext blocks on a valid/ready stream and applies CBC chaining (XOR with the IV or the previous ciphertext). Drives the core's plain_text, key and start inputs, then waits for the core's dat_valid.
- Captures the core's cipher_text, updates the chaining register and presents the result on an output valid/ready stream.
- One block is in flight at a time. ECB is selectable by parameter.

---
 rtl/des_pkg.sv | 24 ++
 rtl/des_cbc_ctrl_if.sv | 35 +++
 rtl/des_timeout_cnt.sv | 44 ++++
 rtl/des_cbc_ctrl.sv | 116 +++++++++++
 tb/tb_des_cbc_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// Shared types and constants for the DES block-mode sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: block width, default core timeout, FSM state encoding, counter width helper.
package des_pkg;

    localparam int DES_BLK_W           = 64;
    localparam int DES_TIMEOUT_CYC_DEF = 32;

    typedef logic [DES_BLK_W-1:0] des_blk_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUT    = 2'd3
    } des_state_e;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/des_cbc_ctrl_if.sv
// Bundle of every stream, core-side and status signal of the DES block sequencer.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
// Modports: slave = the sequencer itself, master = its environment (source, sink, core).
interface des_cbc_ctrl_if;
    import des_pkg::*;

    des_blk_t key_in;
    des_blk_t iv_in;
    logic     iv_load;
    des_blk_t in_data;
    logic     in_valid;
    logic     in_ready;
    des_blk_t out_data;
    logic     out_valid;
    logic     out_ready;
    des_blk_t core_plain;
    des_blk_t core_key;
    logic     core_start;
    des_blk_t core_cipher;
    logic     core_done;
    logic     busy;
    logic     err_timeout;

    modport slave (
        input  key_in, iv_in, iv_load, in_data, in_valid, out_ready, core_cipher, core_done,
        output in_ready, out_data, out_valid, core_plain, core_key, core_start, busy, err_timeout
    );

    modport master (
        output key_in, iv_in, iv_load, in_data, in_valid, out_ready, core_cipher, core_done,
        input  in_ready, out_data, out_valid, core_plain, core_key, core_start, busy, err_timeout
    );

endinterface

// File: rtl/des_timeout_cnt.sv
// Saturating watchdog counter with synchronous clear and enable, plus terminal flag.
// Latency: count updates one cycle after enable; term_o is combinational from this cycle's inputs.
// Backpressure: none; clear wins over enable, count sticks at MAX_CNT.
// Ports: clk, rst (sync, active-high), clr_i, en_i, term_o (count reaches MAX_CNT on this enable).
module des_timeout_cnt
    import des_pkg::*;
#(
    parameter int MAX_CNT = DES_TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam int                CNT_W = cnt_width(MAX_CNT);
    localparam logic [CNT_W-1:0]  MAX_V = CNT_W'(MAX_CNT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the enabled cycle that takes the count to MAX_CNT, and on any
    // further enabled cycle once saturated.
    assign term_o = !clr_i && en_i && (cnt_d == MAX_V);

endmodule

// File: rtl/des_cbc_ctrl.sv
// Block-mode sequencer around the iterative DES core: CBC/ECB chaining, start pulse, result capture.
// Latency: core_start one cycle after input handshake; out_valid one cycle after core_done.
// Backpressure: one block in flight; in_ready low from accept until the output handshake completes.
// Ports: clk, rst (sync, active-high), bus (des_cbc_ctrl_if.slave: in/out streams, core_* pins, busy, err_timeout).
module des_cbc_ctrl
    import des_pkg::*;
#(
    parameter bit MODE_CBC    = 1'b1,
    parameter int TIMEOUT_CYC = DES_TIMEOUT_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    des_cbc_ctrl_if.slave bus
);

    des_state_e state_q;
    des_blk_t   chain_q;
    des_blk_t   core_plain_q;
    des_blk_t   core_key_q;
    des_blk_t   out_data_q;
    logic       core_start_q;
    logic       out_valid_q;
    logic       busy_q;
    logic       err_timeout_q;

    des_blk_t   plain_d;
    logic       in_ready_w;
    logic       in_acc_w;
    logic       timeout_w;

    // In ECB the chain register never reaches the core.
    assign plain_d    = MODE_CBC ? (bus.in_data ^ chain_q) : bus.in_data;

    // An IV load owns the IDLE cycle; a coincident block waits one cycle.
    assign in_ready_w = (state_q == ST_IDLE) && !bus.iv_load;
    assign in_acc_w   = bus.in_valid && in_ready_w;

    des_timeout_cnt #(
        .MAX_CNT (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == ST_LAUNCH),
        .en_i   (state_q == ST_WAIT),
        .term_o (timeout_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            chain_q       <= '0;
            core_plain_q  <= '0;
            core_key_q    <= '0;
            out_data_q    <= '0;
            core_start_q  <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.iv_load) begin
                        chain_q <= bus.iv_in;
                    end else if (in_acc_w) begin
                        // core_plain/core_key stay frozen until the next accept:
                        // the core reads them combinationally on every round.
                        core_plain_q <= plain_d;
                        core_key_q   <= bus.key_in;
                        core_start_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    core_start_q <= 1'b0;
                    state_q      <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A result arriving on the timeout cycle is still taken.
                    if (bus.core_done) begin
                        out_data_q  <= bus.core_cipher;
                        if (MODE_CBC) begin
                            chain_q <= bus.core_cipher;
                        end
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else if (timeout_w) begin
                        err_timeout_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.core_plain  = core_plain_q;
    assign bus.core_key    = core_key_q;
    assign bus.core_start  = core_start_q;
    assign bus.busy        = busy_q;
    assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Testbench for des_cbc_ctrl: CBC instance driven from a vector table plus corner sequences, ECB instance spot-checked.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low with a pending input block.
module tb_des_cbc_ctrl;

    localparam logic [63:0] K    = 64'h133457799BBCDFF1;
    localparam logic [63:0] P0   = 64'h0123456789ABCDEF;
    localparam logic [63:0] C0   = 64'h85E813540F0AB405;
    localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;
    localparam int          C_LAT = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    des_cbc_ctrl_if ifc ();
    des_cbc_ctrl_if ife ();

    des_cbc_ctrl #(.MODE_CBC(1'b1), .TIMEOUT_CYC(32)) u_cbc (.clk(clk), .rst(rst), .bus(ifc));
    des_cbc_ctrl #(.MODE_CBC(1'b0), .TIMEOUT_CYC(32)) u_ecb (.clk(clk), .rst(rst), .bus(ife));

    // Stand-in for the DES core: the known vector, otherwise an invertible mix.
    function automatic logic [63:0] fake_des(input logic [63:0] p, input logic [63:0] k);
        if (p == P0 && k == K) return C0;
        return ~(p ^ k);
    endfunction

    // Core model for the CBC instance: result C_LAT cycles after start, garbage on cipher otherwise.
    int          c_cnt   = 0;
    bit          c_hang  = 1'b0;
    int          inj_req = 0;
    int          inj_ack = 0;
    logic [63:0] c_p, c_k;
    always @(negedge clk) begin
        ifc.core_done   = 1'b0;
        ifc.core_cipher = {$urandom, $urandom};
        if (ifc.core_start === 1'b1) begin
            c_p   = ifc.core_plain;
            c_k   = ifc.core_key;
            c_cnt = C_LAT;
        end else if (c_cnt > 0) begin
            c_cnt--;
            if (c_cnt == 0 && !c_hang) begin
                ifc.core_done   = 1'b1;
                ifc.core_cipher = fake_des(c_p, c_k);
            end
        end
        if (inj_req != inj_ack) begin
            inj_ack       = inj_req;
            ifc.core_done = 1'b1;
        end
    end

    // Core model for the ECB instance.
    int          e_cnt = 0;
    logic [63:0] e_p, e_k;
    always @(negedge clk) begin
        ife.core_done = 1'b0;
        if (ife.core_start === 1'b1) begin
            e_p   = ife.core_plain;
            e_k   = ife.core_key;
            e_cnt = 3;
        end else if (e_cnt > 0) begin
            e_cnt--;
            if (e_cnt == 0) begin
                ife.core_done   = 1'b1;
                ife.core_cipher = fake_des(e_p, e_k);
            end
        end
    end

    typedef struct {
        logic        load;
        logic [63:0] iv;
        logic [63:0] data;
        logic [63:0] key;
        logic [63:0] exp_plain;
        logic [63:0] exp_out;
    } vec_t;

    vec_t        tbl[5];
    logic [63:0] exp_plain_q[$];
    logic [63:0] exp_out_q[$];
    logic [63:0] cur_plain, cur_key;
    int          checks   = 0;
    int          failures = 0;
    bit          in_hs, out_hs, start_seen;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One clock: observe settled values just before the edge, then step past it.
    task automatic cyc();
        in_hs      = 1'b0;
        out_hs     = 1'b0;
        start_seen = 1'b0;
        @(negedge clk);
        #1;
        if (ifc.in_valid === 1'b1 && ifc.in_ready === 1'b1) in_hs = 1'b1;
        if (ifc.core_start === 1'b1) begin
            start_seen = 1'b1;
            if (exp_plain_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_start: core_start=1 with no block expected");
            end else begin
                cur_plain = exp_plain_q.pop_front();
                chk("core_plain", ifc.core_plain, cur_plain);
                chk("core_key", ifc.core_key, cur_key);
            end
        end
        if (ifc.core_done === 1'b1 && ifc.busy === 1'b1) chk("plain_hold", ifc.core_plain, cur_plain);
        if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
            out_hs = 1'b1;
            if (exp_out_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_out: out_data=%h with nothing expected", ifc.out_data);
            end else begin
                chk("out_data", ifc.out_data, exp_out_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer a block until accepted, then expect core_start on the very next cycle.
    task automatic send(input logic [63:0] d, input logic [63:0] k);
        int n = 0;
        cur_key      = k;
        ifc.in_data  = d;
        ifc.key_in   = k;
        ifc.in_valid = 1'b1;
        do begin
            cyc();
            n++;
        end while (!in_hs && n < 64);
        ifc.in_valid = 1'b0;
        chk("in_accept", 64'(in_hs), 64'd1);
        cyc();
        chk("start_lat", 64'(start_seen), 64'd1);
    endtask

    task automatic wait_out(input string nm);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!out_hs && n < 64);
        chk(nm, 64'(out_hs), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  saw;
        int  e_starts;
        bit  e_out;

        tbl[0] = '{1'b1, P0,   64'h0, K,     P0,    C0};
        tbl[1] = '{1'b0, 64'h0, C0,   K,     64'h0, ~K};
        tbl[2] = '{1'b0, 64'h0, ONES, K,     K,     ONES};
        tbl[3] = '{1'b1, ONES, 64'h0, 64'h0, ONES,  64'h0};
        tbl[4] = '{1'b0, 64'h0, P0,   K,     P0,    C0};

        {ifc.iv_load, ifc.in_valid, ifc.out_ready} = 3'b001;
        {ifc.iv_in, ifc.in_data, ifc.key_in} = '0;
        {ife.iv_load, ife.in_valid, ife.out_ready} = 3'b001;
        {ife.iv_in, ife.in_data, ife.key_in, ife.core_cipher} = '0;
        cur_key   = '0;
        cur_plain = '0;

        // Reset state
        repeat (3) cyc();
        rst = 1'b0;
        #1;
        chk("rst_busy", 64'(ifc.busy), 64'd0);
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_core_start", 64'(ifc.core_start), 64'd0);
        chk("rst_err", 64'(ifc.err_timeout), 64'd0);
        chk("rst_core_plain", ifc.core_plain, 64'h0);
        chk("rst_core_key", ifc.core_key, 64'h0);
        chk("rst_out_data", ifc.out_data, 64'h0);
        chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("rst_ecb_busy", 64'(ife.busy), 64'd0);

        // ECB instance: a loaded IV must not reach the core
        ife.iv_in   = ONES;
        ife.iv_load = 1'b1;
        cyc();
        ife.iv_load  = 1'b0;
        ife.in_data  = P0;
        ife.key_in   = K;
        ife.in_valid = 1'b1;
        e_starts = 0;
        e_out    = 1'b0;
        for (int i = 0; i < 40 && !e_out; i++) begin
            cyc();
            if (ife.busy === 1'b1) ife.in_valid = 1'b0;
            if (ife.core_start === 1'b1) begin
                e_starts++;
                chk("ecb_core_plain", ife.core_plain, P0);
            end
            if (ife.out_valid === 1'b1) begin
                e_out = 1'b1;
                chk("ecb_out_data", ife.out_data, C0);
            end
        end
        ife.in_valid = 1'b0;
        chk("ecb_out_seen", 64'(e_out), 64'd1);
        chk("ecb_start_pulses", 64'(e_starts), 64'd1);

        // CBC vector table
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].load) begin
                ifc.iv_in   = tbl[i].iv;
                ifc.iv_load = 1'b1;
                cyc();
                ifc.iv_load = 1'b0;
            end
            exp_plain_q.push_back(tbl[i].exp_plain);
            exp_out_q.push_back(tbl[i].exp_out);
            send(tbl[i].data, tbl[i].key);
            wait_out("tbl_out_hs");
        end

        // Backpressure: chain is C0; block A -> plain 0, cipher ~K; block B pending
        ifc.out_ready = 1'b0;
        exp_plain_q.push_back(64'h0);
        exp_out_q.push_back(~K);
        send(C0, K);
        n = 0;
        while (ifc.out_valid !== 1'b1 && n < 64) begin
            cyc();
            n++;
        end
        chk("bp_out_valid", 64'(ifc.out_valid), 64'd1);
        exp_plain_q.push_back(K);
        exp_out_q.push_back(ONES);
        cur_key      = K;
        ifc.in_data  = ONES;
        ifc.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("bp_hold_valid", 64'(ifc.out_valid), 64'd1);
            chk("bp_hold_data", ifc.out_data, ~K);
            chk("bp_in_ready", 64'(ifc.in_ready), 64'd0);
            chk("bp_no_accept", 64'(in_hs), 64'd0);
        end
        ifc.out_ready = 1'b1;
        cyc();
        chk("bp_out_hs", 64'(out_hs), 64'd1);
        chk("bp_no_accept_hs", 64'(in_hs), 64'd0);
        ifc.out_ready = 1'b0;
        cyc();
        chk("bp_accept_next", 64'(in_hs), 64'd1);
        ifc.in_valid = 1'b0;
        cyc();
        chk("bp_start_lat", 64'(start_seen), 64'd1);
        ifc.out_ready = 1'b1;
        wait_out("bp_b_out_hs");

        // Timeout: chain is ONES, core never answers
        c_hang = 1'b1;
        exp_plain_q.push_back(64'hEEEEEEEEEEEEEEEE);
        send(64'h1111111111111111, K);
        n   = 0;
        saw = 1'b0;
        while (ifc.err_timeout !== 1'b1 && n < 40) begin
            cyc();
            n++;
            if (ifc.out_valid !== 1'b0) saw = 1'b1;
        end
        chk("tmo_err", 64'(ifc.err_timeout), 64'd1);
        chk("tmo_wait_cycles", 64'(n), 64'd32);
        chk("tmo_no_out", 64'(saw), 64'd0);
        chk("tmo_busy", 64'(ifc.busy), 64'd0);
        chk("tmo_in_ready", 64'(ifc.in_ready), 64'd1);
        c_hang = 1'b0;
        repeat (3) cyc();
        // Chain must still be ONES
        exp_plain_q.push_back(ONES);
        exp_out_q.push_back(K);
        send(64'h0, K);
        wait_out("tmo_next_out_hs");
        chk("tmo_err_sticky", 64'(ifc.err_timeout), 64'd1);

        // iv_load beats a simultaneous in_valid
        exp_plain_q.push_back(P0);
        exp_out_q.push_back(C0);
        cur_key      = K;
        ifc.iv_in    = P0;
        ifc.iv_load  = 1'b1;
        ifc.in_data  = 64'h0;
        ifc.key_in   = K;
        ifc.in_valid = 1'b1;
        cyc();
        chk("prio_in_ready", 64'(ifc.in_ready), 64'd0);
        chk("prio_no_accept", 64'(in_hs), 64'd0);
        ifc.iv_load = 1'b0;
        cyc();
        chk("prio_accept_next", 64'(in_hs), 64'd1);
        ifc.in_valid = 1'b0;
        cyc();
        chk("prio_start_lat", 64'(start_seen), 64'd1);
        wait_out("prio_out_hs");

        // Stray core_done in IDLE is ignored (chain stays C0)
        inj_req++;
        saw = 1'b0;
        repeat (4) begin
            cyc();
            if (ifc.busy !== 1'b0 || ifc.out_valid !== 1'b0) saw = 1'b1;
        end
        chk("stray_done_idle", 64'(saw), 64'd0);

        // Reset while waiting on the core
        exp_plain_q.push_back(C0);
        send(64'h0, K);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("wrst_busy", 64'(ifc.busy), 64'd0);
        chk("wrst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("wrst_core_start", 64'(ifc.core_start), 64'd0);
        chk("wrst_core_plain", ifc.core_plain, 64'h0);
        chk("wrst_core_key", ifc.core_key, 64'h0);
        chk("wrst_out_data", ifc.out_data, 64'h0);
        chk("wrst_err", 64'(ifc.err_timeout), 64'd0);
        saw = 1'b0;
        repeat (10) begin
            cyc();
            if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0) saw = 1'b1;
        end
        chk("wrst_late_done_ignored", 64'(saw), 64'd0);
        // Chain was cleared by reset
        exp_plain_q.push_back(P0);
        exp_out_q.push_back(C0);
        send(P0, K);
        wait_out("wrst_next_out_hs");
        repeat (2) cyc();
        chk("left_exp_out", 64'(exp_out_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
